// File: rtl/keypad_scanner_fifo.sv
// rtl/keypad_scanner_fifo.sv - matrix keypad scanner with debounce, auto-repeat and key-code FIFO
module keypad_scanner_fifo #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SCAN_PERIOD   = 32768,
    parameter int DEBOUNCE      = 12,
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_FRAMES = 0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [ROWS-1:0] rowwrite,
    input  logic [COLS-1:0] colread,
    input  logic            ack,
    input  logic            statusordata,
    output logic [15:0]     keyout
);
    localparam int KW = $clog2(ROWS * COLS);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DW-1:0] r_div;
    logic [RW-1:0] r_row;
    logic          r_fr_v, r_cand_v, r_acc_v, r_ovf;
    logic [KW-1:0] r_fr_code, r_cand_code, r_acc_code;
    logic [15:0]   r_stab, r_rep;
    logic [KW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [7:0]    r_count;

    logic          w_tick, w_done, w_found, w_f_v, w_same, w_diff_acc;
    logic          w_accept, w_repeat, w_push, w_pop, w_full, w_wr;
    logic [CW-1:0] w_col;
    logic [KW-1:0] w_code, w_f_code, w_push_code;
    logic [15:0]   w_stab_nx, w_rep_nx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_tick   = (r_div == DW'(SCAN_PERIOD - 1));
    assign w_done   = w_tick && (r_row == RW'(ROWS - 1));
    assign rowwrite = ~(ROWS'(1) << r_row);

    // Descending scan so the lowest pressed column wins.
    always_comb begin
        w_found = 1'b0;
        w_col   = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!colread[c]) begin
                w_found = 1'b1;
                w_col   = CW'(c);
            end
        end
    end

    // Earlier rows of the frame take priority; row 0 starts a fresh frame.
    always_comb begin
        w_code   = KW'(r_row) * KW'(COLS) + KW'(w_col);
        w_f_v    = 1'b0;
        w_f_code = w_code;
        if (r_row != '0 && r_fr_v) begin
            w_f_v    = 1'b1;
            w_f_code = r_fr_code;
        end else if (w_found) begin
            w_f_v    = 1'b1;
        end
    end

    always_comb begin
        w_same      = (w_f_v == r_cand_v) && (!w_f_v || w_f_code == r_cand_code);
        w_stab_nx   = 16'd1;
        if (w_same)
            w_stab_nx = (r_stab < 16'(DEBOUNCE)) ? r_stab + 16'd1 : r_stab;
        w_diff_acc  = (w_f_v != r_acc_v) || (w_f_v && w_f_code != r_acc_code);
        w_accept    = w_done && (w_stab_nx >= 16'(DEBOUNCE)) && w_diff_acc;
        w_rep_nx    = r_rep + 16'd1;
        w_repeat    = (REPEAT_FRAMES > 0) && w_done && !w_accept && r_acc_v
                      && (w_rep_nx == 16'(REPEAT_FRAMES));
        w_push      = (w_accept && w_f_v) || w_repeat;
        w_push_code = w_accept ? w_f_code : r_acc_code;
        w_pop       = ack && !statusordata && (r_count != 8'd0);
        w_full      = (r_count == 8'(FIFO_DEPTH));
        w_wr        = w_push && (!w_full || w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_row       <= '0;
            r_fr_v      <= 1'b0;
            r_fr_code   <= '0;
            r_cand_v    <= 1'b0;
            r_cand_code <= '0;
            r_acc_v     <= 1'b0;
            r_acc_code  <= '0;
            r_stab      <= '0;
            r_rep       <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_row     <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
                r_fr_v    <= w_f_v;
                r_fr_code <= w_f_code;
            end
            if (w_done) begin
                r_cand_v    <= w_f_v;
                r_cand_code <= w_f_code;
                r_stab      <= w_stab_nx;
                if (w_accept) begin
                    r_acc_v    <= w_f_v;
                    r_acc_code <= w_f_code;
                    r_rep      <= '0;
                end else if (r_acc_v) begin
                    r_rep <= w_repeat ? '0 : w_rep_nx;
                end
            end
            if (w_wr)
                r_tail <= ptr_inc(r_tail);
            if (w_pop)
                r_head <= ptr_inc(r_head);
            r_count <= r_count + {7'd0, w_wr} - {7'd0, w_pop};
            // A dropped push outranks a same-cycle status acknowledge.
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (ack && statusordata)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_tail] <= w_push_code;
    end

    always_comb begin
        keyout = '0;
        if (statusordata)
            keyout = {r_count, 5'd0, r_acc_v, r_ovf, (r_count != 8'd0)};
        else if (r_count != 8'd0)
            keyout = {{(16 - KW){1'b0}}, r_mem[r_head]};
    end
endmodule

// File: doc/keypad_scanner_fifo.md
# keypad_scanner_fifo

Parametrised matrix-keypad scanner for ROWS×COLS active-low keypads. It drives one row low at a time and samples the columns. Per-frame key codes are debounced, and each new key press is pushed into a key-code FIFO, with optional auto-repeat. The block sits on the same status/data read port used by the CPU-side keypad interface, so firmware polls status, reads a code and acks it to pop.

## Interface
- ROWS, 4, number of row drive lines (2..8)
- COLS, 4, number of column sense lines (2..8)
- SCAN_PERIOD, 32768, clk cycles per row step (≥2)
- DEBOUNCE, 12, consecutive identical frames needed to accept a state change (≥1)
- FIFO_DEPTH, 4, key-code FIFO entries (1..255)
- REPEAT_FRAMES, 0, frames between auto-repeat pushes of a held key; 0 = auto-repeat disabled
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rowwrite  output  ROWS  row drive, active-low one-hot
- colread  input  COLS  column sense, active-low (1 = not pressed)
- ack  input  1  read acknowledge, one cycle per access
- statusordata  input  1  1 = status word on keyout, 0 = head key code on keyout
- keyout  output  16  read data (combinational from registers)

## Operation
- Key code = row*COLS + col, width KW = clog2(ROWS*COLS); zero-extended on keyout.
- Divider counts 0..SCAN_PERIOD-1; terminal count is a scan tick.
- On a tick: colread is latched as the sample of the row currently driven low (index r), then rowwrite rotates so row r+1 mod ROWS is driven low.
- Frame completes on the tick that samples row ROWS-1. Frame code is the lowest code with its colread bit = 0, or NONE if nothing is pressed. Multiple presses resolve to the lowest code.
- Debounce:
  - A candidate register holds the last frame code; a stability counter increments when the frame code equals the candidate and resets to 1 otherwise.
  - When the counter reaches DEBOUNCE and candidate ≠ accepted, accepted ← candidate.
  - DEBOUNCE=1 accepts on the first differing frame.
- Push events:
  - Accepted changes to a non-NONE value X (from NONE or from another key): push X.
  - Auto-repeat (REPEAT_FRAMES>0): while accepted = X ≠ NONE, push X every REPEAT_FRAMES completed frames after the acceptance frame. The repeat counter restarts on every accepted change.
  - A change to NONE pushes nothing.
- FIFO is a circular buffer with head/tail pointers wrapping at FIFO_DEPTH, plus a count 0..FIFO_DEPTH.
- Status word: bit0 ready (count≠0), bit1 overflow (sticky), bit2 held (accepted≠NONE), bits[15:8] count, other bits 0.
- Data word: head entry zero-extended; 0 when the FIFO is empty.
- ack with statusordata=0 and count≠0 pops one entry. ack with statusordata=0 and empty is ignored.
- ack with statusordata=1 clears overflow and never pops.

## Timing
- Reset (rst=1 at a clk edge), all registers cleared next edge:
  - rowwrite = ~1 (row 0 low), divider 0, candidate/accepted NONE, stability and repeat counters 0.
  - FIFO count 0, pointers 0, overflow 0.
  - keyout therefore reads 0 in both modes.
- Reset mid-scan or mid-read discards all FIFO contents and any in-progress debounce.
- Push occurs on the same edge that updates accepted (or on the repeat frame edge). ready is visible on keyout the cycle after that edge.
- Pop takes effect at the ack edge; the next entry is on keyout in the following cycle.
- Push and pop in the same cycle: both are performed and count is unchanged. This applies when full too, with no overflow.
- Push while full with no pop: the code is dropped, overflow ← 1, FIFO unchanged.
- Overflow set and clear-ack in the same cycle: set wins.
- Sample-to-accept latency: DEBOUNCE frames = DEBOUNCE*ROWS*SCAN_PERIOD cycles, measured from the first frame containing the new state.
- ack held high for several cycles pops one entry per cycle. Bus masters must pulse ack.

## Test plan
- Reset with ROWS=COLS=4, SCAN_PERIOD=4, DEBOUNCE=3 -> rowwrite=1110, keyout=0 in both modes; rowwrite steps 1101, 1011, 0111, 1110 every 4 cycles.
- Hold row 1/col 2 (colread=1011 whenever rowwrite=1101) for 5 frames -> exactly one push of code 6 after the 3rd frame; status reads 0x0105 (count 1, held, ready); data reads 6; data ack -> status 0x0004.
- Glitch the press for 2 frames then release -> nothing pushed, status bit2 stays 0; press for 3 frames -> pushed.
- FIFO_DEPTH=2: press/release codes 1, 2, 3 with no acks -> count 2, overflow=1, reads return 1 then 2; status ack clears overflow.
- REPEAT_FRAMES=2, hold code 0 for 9 frames after acceptance -> pushes at acceptance and at +2, +4, +6, +8 frames (5 entries, limited by FIFO_DEPTH, overflow set).
- Keys 5 and 9 pressed simultaneously -> code 5 pushed only; push coinciding with a pop on a full FIFO -> count stays full, overflow stays 0.
